// File: rtl/mitchell_pkg.sv
// Shared definitions for the sequential Mitchell approximate multiplier.
// Holds the FSM state encoding and the datapath width constants used by
// mitchell_mult_seq, lod and mitchell_antilog.
package mitchell_pkg;

  localparam int OP_W   = 8;   // operand width
  localparam int FRAC_W = 7;   // normalized fraction width from the LOD
  localparam int K_W    = 3;   // leading-one position width
  localparam int PROD_W = 16;  // product width
  localparam int KSUM_W = 4;   // ka+kb, max 14
  localparam int F_W    = 8;   // xa+xb, max 254
  localparam int WIDE_W = 23;  // antilog shift intermediate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOD_A = 3'd1,
    S_LOD_B = 3'd2,
    S_CALC  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  // Zero-operand detect, shared by the input capture path.
  function automatic logic zero_pair(input logic [OP_W-1:0] av,
                                     input logic [OP_W-1:0] bv);
    return (av == 8'd0) || (bv == 8'd0);
  endfunction

endpackage

// File: rtl/lod.sv
// 8-bit leading-one detector.
//   data : operand to analyse
//   k    : bit position of the most significant one (0 when data==0)
//   x    : bits below the leading one, left-aligned into 7 bits
module lod
  import mitchell_pkg::*;
(
  input  logic [OP_W-1:0]   data,
  output logic [K_W-1:0]    k,
  output logic [FRAC_W-1:0] x
);

  // Priority encode the most significant set bit.
  always_comb begin
    k = 3'd0;
    casez (data)
      8'b1???????: k = 3'd7;
      8'b01??????: k = 3'd6;
      8'b001?????: k = 3'd5;
      8'b0001????: k = 3'd4;
      8'b00001???: k = 3'd3;
      8'b000001??: k = 3'd2;
      8'b0000001?: k = 3'd1;
      default:     k = 3'd0;
    endcase
  end

  // Shifting {data,0000000} right by k drops the leading one into bit 7,
  // leaving exactly the fraction bits in [6:0].
  always_comb begin
    x = 7'(({data, 7'd0}) >> k);
  end

endmodule

// File: rtl/mitchell_antilog.sv
// Mitchell log-add result to linear product (combinational).
//   ksum : ka+kb
//   f    : xa+xb; bit 7 set means the fraction sum carried past 1.0
//   z    : force the product to zero
//   p    : approximate product, truncated toward zero
module mitchell_antilog
  import mitchell_pkg::*;
(
  input  logic [KSUM_W-1:0] ksum,
  input  logic [F_W-1:0]    f,
  input  logic              z,
  output logic [PROD_W-1:0] p
);

  logic [WIDE_W-1:0] mant_s;
  logic [WIDE_W-1:0] wide_s;

  // Without carry the mantissa is 1.f (scale 2^7); with carry the sum f
  // itself already represents 2*(1.(f-1)) at scale 2^6.
  always_comb begin
    mant_s = 23'd0;
    if (f[7]) begin
      mant_s = {15'd0, f};
    end else begin
      mant_s = {15'd0, 1'b1, f[6:0]};
    end
    wide_s = mant_s << ksum;
  end

  // Undo the fixed-point scale and apply the zero override.
  always_comb begin
    p = 16'd0;
    if (z) begin
      p = 16'd0;
    end else if (f[7]) begin
      p = 16'(wide_s >> 6);
    end else begin
      p = 16'(wide_s >> 7);
    end
  end

endmodule

// File: rtl/mitchell_mult_seq.sv
// Sequential Mitchell approximate 8x8 multiplier with valid/ready on both
// sides. One lod instance is time-shared between operand A and B.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake, a and b captured on transfer
//   out_valid/out_ready : result handshake, product held until accepted
//   product             : approximate a*b, keeps its value until reset
//   busy                : high whenever the FSM is not idle
module mitchell_mult_seq
  import mitchell_pkg::*;
#(
  parameter int ZERO_DET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_t              state_r, state_next_s;
  logic [OP_W-1:0]     a_r, b_r;
  logic                z_r;
  logic [K_W-1:0]      ka_r, kb_r;
  logic [FRAC_W-1:0]   xa_r, xb_r;
  logic [PROD_W-1:0]   product_r;

  logic                accept_s;
  logic                load_a_s, load_b_s, load_p_s;
  logic [OP_W-1:0]     lod_data_s;
  logic [K_W-1:0]      lod_k_s;
  logic [FRAC_W-1:0]   lod_x_s;
  logic [KSUM_W-1:0]   ksum_s;
  logic [F_W-1:0]      f_s;
  logic [PROD_W-1:0]   p_s;

  lod u_lod (
    .data (lod_data_s),
    .k    (lod_k_s),
    .x    (lod_x_s)
  );

  assign ksum_s = {1'b0, ka_r} + {1'b0, kb_r};
  assign f_s    = {1'b0, xa_r} + {1'b0, xb_r};

  mitchell_antilog u_antilog (
    .ksum (ksum_s),
    .f    (f_s),
    .z    (z_r),
    .p    (p_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          state_next_s = S_LOD_A;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOD_A: state_next_s = S_LOD_B;
      S_LOD_B: state_next_s = S_CALC;
      S_CALC:  state_next_s = S_OUT;
      S_OUT: begin
        if (out_ready && in_valid) begin
          state_next_s = S_LOD_A;
        end else if (out_ready) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_OUT;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State-decoded outputs, LOD operand mux and datapath load enables.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    lod_data_s = 8'd0;
    load_a_s   = 1'b0;
    load_b_s   = 1'b0;
    load_p_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_LOD_A: begin
        lod_data_s = a_r;
        load_a_s   = 1'b1;
      end
      S_LOD_B: begin
        lod_data_s = b_r;
        load_b_s   = 1'b1;
      end
      S_CALC: load_p_s = 1'b1;
      S_OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
    endcase
  end

  assign accept_s = in_valid & in_ready;

  // Operand capture, LOD results and product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= 8'd0;
      b_r       <= 8'd0;
      z_r       <= 1'b0;
      ka_r      <= 3'd0;
      xa_r      <= 7'd0;
      kb_r      <= 3'd0;
      xb_r      <= 7'd0;
      product_r <= 16'd0;
    end else begin
      if (accept_s) begin
        a_r <= a;
        b_r <= b;
        z_r <= (ZERO_DET != 0) && zero_pair(a, b);
      end
      if (load_a_s) begin
        ka_r <= lod_k_s;
        xa_r <= lod_x_s;
      end
      if (load_b_s) begin
        kb_r <= lod_k_s;
        xb_r <= lod_x_s;
      end
      if (load_p_s) begin
        product_r <= p_s;
      end
    end
  end

  assign product = product_r;

endmodule

// File: tb/tb_mitchell_mult_seq.sv
// Directed self-checking bench for mitchell_mult_seq. A second instance with
// ZERO_DET=0 shares all inputs so the raw-Mitchell zero behaviour is visible.
module tb_mitchell_mult_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  logic        in_ready_nz;
  logic        out_valid_nz;
  logic [15:0] product_nz;
  logic        busy_nz;

  int errors = 0;
  int checks = 0;

  mitchell_mult_seq #(.ZERO_DET(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  mitchell_mult_seq #(.ZERO_DET(0)) dut_nz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nz),
    .a(a), .b(b), .out_valid(out_valid_nz), .out_ready(out_ready),
    .product(product_nz), .busy(busy_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operand pair at a negedge and wait (bounded) until out_valid.
  // cyc counts negedges from the drive point; 4 means out_valid at T+4.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output logic [15:0] pv, output int cyc);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    pv = product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 8'd0;
    b = 8'd0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'd0) begin
      errors++;
      $display("FAIL reset got in_ready=%b out_valid=%b busy=%b product=%0d exp 1 0 0 0",
               in_ready, out_valid, busy, product);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] pv;
    int cyc;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_in_ready got=%b exp=1", in_ready);
    end
    run_op(8'd3, 8'd3, pv, cyc);
    checks++;
    if (cyc !== 4) begin
      errors++;
      $display("FAIL latency got=%0d exp=4", cyc);
    end
    checks++;
    if (pv !== 16'd8) begin
      errors++;
      $display("FAIL prod_3x3 got=%0d exp=8", pv);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_out got=%b exp=1", busy);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_xfer got out_valid=%b busy=%b in_ready=%b exp 0 0 1",
               out_valid, busy, in_ready);
    end
    checks++;
    if (product !== 16'd8) begin
      errors++;
      $display("FAIL prod_retained got=%0d exp=8", product);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] pv;
    int cyc;
    run_op(8'd255, 8'd255, pv, cyc);
    checks++;
    if (pv !== 16'd65024) begin
      errors++;
      $display("FAIL prod_255x255 got=%0d exp=65024", pv);
    end
    @(negedge clk);
    run_op(8'd4, 8'd4, pv, cyc);
    checks++;
    if (pv !== 16'd16) begin
      errors++;
      $display("FAIL prod_4x4 got=%0d exp=16", pv);
    end
    @(negedge clk);
    run_op(8'd1, 8'd1, pv, cyc);
    checks++;
    if (pv !== 16'd1) begin
      errors++;
      $display("FAIL prod_1x1 got=%0d exp=1", pv);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [15:0] pv;
    int cyc;
    run_op(8'd0, 8'd5, pv, cyc);
    checks++;
    if (pv !== 16'd0) begin
      errors++;
      $display("FAIL zero_det1 got=%0d exp=0", pv);
    end
    checks++;
    if (out_valid_nz !== 1'b1 || product_nz !== 16'd5) begin
      errors++;
      $display("FAIL zero_det0 got valid=%b product=%0d exp 1 5", out_valid_nz, product_nz);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] pv;
    int cyc;
    out_ready = 1'b0;
    run_op(8'd6, 8'd7, pv, cyc);
    checks++;
    if (pv !== 16'd40) begin
      errors++;
      $display("FAIL prod_6x7 got=%0d exp=40", pv);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || product !== 16'd40 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got valid=%b product=%0d in_ready=%b exp 1 40 0",
                 i, out_valid, product, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    out_ready = 1'b1;
    a = 8'd3;
    b = 8'd5;
    in_valid = 1'b1;
    @(negedge clk);
    a = 8'd10;
    b = 8'd12;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_ready got=%b exp=0", in_ready);
    end
    gap = 1;
    while (out_valid !== 1'b1 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (product !== 16'd14 || in_ready !== 1'b1 || gap !== 4) begin
      errors++;
      $display("FAIL b2b_first got product=%0d in_ready=%b cyc=%0d exp 14 1 4",
               product, in_ready, gap);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart got valid=%b busy=%b exp 0 1", out_valid, busy);
    end
    gap = 1;
    while (out_valid !== 1'b1 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (product !== 16'd112 || gap !== 4) begin
      errors++;
      $display("FAIL b2b_second got product=%0d gap=%0d exp 112 4", product, gap);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic seen;
    a = 8'd9;
    b = 8'd9;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy got=%b exp=1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || product !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got valid=%b product=%0d busy=%b in_ready=%b exp 0 0 0 1",
               out_valid, product, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL spurious_out got=%b exp=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
